map2pixel_stream: RTL and testbench

Streaming converter from map coordinates to screen pixel coordinates, the inverse of the display's pixel-to-map lookup. It accepts a stream of map points (trajectory samples, position marker, waypoints), applies the current pan centre (m,n) and zoom rate, and drops points that fall off the 320x240 view. Visible points are emitted with their on-screen cell position and size to the overlay drawer. The view parameters are frame-synchronous, so a frame never mixes two views.

---
 rtl/map_view_pkg.sv | 29 ++
 rtl/map2pixel_calc.sv | 36 +++
 rtl/map2pixel_stream.sv | 161 ++++++++++++++++
 tb/tb_map2pixel_stream.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/map_view_pkg.sv
// Shared view constants and helpers for the map<->pixel mapping; used by both
// lookup directions so the centre and scale always agree.
package map_view_pkg;

    localparam int SCREEN_W = 320;
    localparam int SCREEN_H = 240;
    localparam int CENTER_X = 160;
    localparam int CENTER_Y = 120;

    typedef enum logic [1:0] {
        RATE_X1 = 2'd0,
        RATE_X2 = 2'd1,
        RATE_X4 = 2'd2,
        RATE_X8 = 2'd3
    } rate_e;

    function automatic logic [3:0] cell_size(input logic [1:0] rate);
        return 4'd1 << rate;
    endfunction

    // Top-left corner test; the sign bit rejects anything left of / above the view.
    function automatic logic in_view(input logic signed [13:0] px,
                                     input logic signed [13:0] py,
                                     input int w,
                                     input int h);
        return !px[13] && (px[12:0] < 13'(w)) && !py[13] && (py[12:0] < 13'(h));
    endfunction

endpackage

// File: rtl/map2pixel_calc.sv
// Combinational map-point to pixel mapping for one view: scaled offset, pixel
// position and visibility. No state, no handshake.
module map2pixel_calc
    import map_view_pkg::*;
#(
    parameter int SCREEN_W = map_view_pkg::SCREEN_W,
    parameter int SCREEN_H = map_view_pkg::SCREEN_H
) (
    input  logic [8:0]         map_x,
    input  logic [8:0]         map_y,
    input  logic [8:0]         m_v,
    input  logic [8:0]         n_v,
    input  logic [1:0]         rate_v,
    output logic signed [13:0] sx,
    output logic signed [13:0] sy,
    output logic signed [13:0] px,
    output logic signed [13:0] py,
    output logic               visible
);

    logic signed [9:0] dx;
    logic signed [9:0] dy;

    // Widen before subtracting so map offsets never wrap at 9 bits.
    assign dx = $signed({1'b0, map_x}) - $signed({1'b0, m_v});
    assign dy = $signed({1'b0, map_y}) - $signed({1'b0, n_v});

    assign sx = $signed({{4{dx[9]}}, dx}) <<< rate_v;
    assign sy = $signed({{4{dy[9]}}, dy}) <<< rate_v;

    assign px = sx + 14'(CENTER_X);
    assign py = sy + 14'(CENTER_Y);

    assign visible = in_view(px, py, SCREEN_W, SCREEN_H);

endmodule

// File: rtl/map2pixel_stream.sv
// Two-stage map->pixel stream with frame-synchronous view, clipping and per-frame
// visible/dropped counters; latency 2, clipped points never stall the pipe.
module map2pixel_stream
    import map_view_pkg::*;
#(
    parameter int CNT_W    = 16,
    parameter int SCREEN_W = 320,
    parameter int SCREEN_H = 240
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frame_start,
    input  logic [8:0]       m,
    input  logic [8:0]       n,
    input  logic [1:0]       rate,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [8:0]       in_map_x,
    input  logic [8:0]       in_map_y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [8:0]       out_px,
    output logic [8:0]       out_py,
    output logic [3:0]       out_size,
    output logic [CNT_W-1:0] frame_visible,
    output logic [CNT_W-1:0] frame_dropped
);

    logic [8:0]  m_v_q, n_v_q;
    logic [1:0]  rate_v_q;

    logic               s1_vld_q;
    logic signed [13:0] s1_sx_q, s1_sy_q;
    logic [1:0]         s1_rate_q;

    logic        out_vld_q;
    logic [8:0]  out_px_q, out_py_q;
    logic [3:0]  out_size_q;

    logic [CNT_W-1:0] vis_cnt_q, vis_cnt_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic [CNT_W-1:0] frame_vis_q, frame_drop_q;

    logic signed [13:0] c_sx, c_sy, c_px, c_py;
    logic               c_vis;
    logic               unused_calc;

    logic               s2_adv, s1_adv;
    logic signed [13:0] s2_px, s2_py;
    logic               s2_vis, vis_ev, drop_ev;

    map2pixel_calc #(
        .SCREEN_W (SCREEN_W),
        .SCREEN_H (SCREEN_H)
    ) u_calc (
        .map_x   (in_map_x),
        .map_y   (in_map_y),
        .m_v     (m_v_q),
        .n_v     (n_v_q),
        .rate_v  (rate_v_q),
        .sx      (c_sx),
        .sy      (c_sy),
        .px      (c_px),
        .py      (c_py),
        .visible (c_vis)
    );

    // Centre add and clip are deferred to S2 to split the adder chain.
    assign unused_calc = ^{c_px, c_py, c_vis};

    assign s2_adv   = !out_vld_q || out_ready;
    assign s1_adv   = s2_adv || !s1_vld_q;
    assign in_ready = s1_adv;

    assign s2_px   = s1_sx_q + 14'(CENTER_X);
    assign s2_py   = s1_sy_q + 14'(CENTER_Y);
    assign s2_vis  = in_view(s2_px, s2_py, SCREEN_W, SCREEN_H);
    assign vis_ev  = s2_adv && s1_vld_q && s2_vis;
    assign drop_ev = s2_adv && s1_vld_q && !s2_vis;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_v_q    <= 9'(CENTER_X);
            n_v_q    <= 9'(CENTER_Y);
            rate_v_q <= RATE_X1;
        end else if (frame_start) begin
            m_v_q    <= m;
            n_v_q    <= n;
            rate_v_q <= rate;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld_q  <= 1'b0;
            s1_sx_q   <= '0;
            s1_sy_q   <= '0;
            s1_rate_q <= RATE_X1;
        end else if (s1_adv) begin
            s1_vld_q <= in_valid;
            if (in_valid) begin
                s1_sx_q   <= c_sx;
                s1_sy_q   <= c_sy;
                s1_rate_q <= rate_v_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_vld_q  <= 1'b0;
            out_px_q   <= '0;
            out_py_q   <= '0;
            out_size_q <= 4'd1;
        end else if (s2_adv) begin
            out_vld_q <= vis_ev;
            if (vis_ev) begin
                out_px_q   <= s2_px[8:0];
                out_py_q   <= s2_py[8:0];
                out_size_q <= cell_size(s1_rate_q);
            end
        end
    end

    always_comb begin
        vis_cnt_d  = vis_cnt_q;
        drop_cnt_d = drop_cnt_q;
        if (vis_ev && (vis_cnt_q != '1)) begin
            vis_cnt_d = vis_cnt_q + 1'b1;
        end
        if (drop_ev && (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + 1'b1;
        end
    end

    // Snapshot takes the already-incremented counts so frame_start-cycle events close the old frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vis_cnt_q    <= '0;
            drop_cnt_q   <= '0;
            frame_vis_q  <= '0;
            frame_drop_q <= '0;
        end else if (frame_start) begin
            vis_cnt_q    <= '0;
            drop_cnt_q   <= '0;
            frame_vis_q  <= vis_cnt_d;
            frame_drop_q <= drop_cnt_d;
        end else begin
            vis_cnt_q  <= vis_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign out_valid     = out_vld_q;
    assign out_px        = out_px_q;
    assign out_py        = out_py_q;
    assign out_size      = out_size_q;
    assign frame_visible = frame_vis_q;
    assign frame_dropped = frame_drop_q;

endmodule

// File: tb/tb_map2pixel_stream.sv
// Directed bench for map2pixel_stream with hand-computed pixel positions,
// frame snapshots, clipping boundaries, backpressure and reset flush.
module tb_map2pixel_stream;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        frame_start = 1'b0;
    logic [8:0]  m = 9'd160, n = 9'd120;
    logic [1:0]  rate = 2'd0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [8:0]  in_map_x = '0, in_map_y = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [8:0]  out_px, out_py;
    logic [3:0]  out_size;
    logic [15:0] frame_visible, frame_dropped;

    logic [8:0]         c_x = '0, c_y = '0, c_m = '0, c_n = '0;
    logic [1:0]         c_rate = '0;
    logic signed [13:0] c_sx, c_sy, c_px, c_py;
    logic               c_vis;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    map2pixel_stream #(.CNT_W(16), .SCREEN_W(320), .SCREEN_H(240)) dut (
        .clk           (clk),
        .rst           (rst),
        .frame_start   (frame_start),
        .m             (m),
        .n             (n),
        .rate          (rate),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_map_x      (in_map_x),
        .in_map_y      (in_map_y),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_px        (out_px),
        .out_py        (out_py),
        .out_size      (out_size),
        .frame_visible (frame_visible),
        .frame_dropped (frame_dropped)
    );

    map2pixel_calc u_ref (
        .map_x (c_x), .map_y (c_y), .m_v (c_m), .n_v (c_n), .rate_v (c_rate),
        .sx (c_sx), .sy (c_sy), .px (c_px), .py (c_py), .visible (c_vis)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_view(input logic [8:0] mm, input logic [8:0] nn, input logic [1:0] rr);
        frame_start = 1'b1; m = mm; n = nn; rate = rr;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic send(input logic [8:0] x, input logic [8:0] y);
        in_valid = 1'b1; in_map_x = x; in_map_y = y;
        tick();
        in_valid = 1'b0;
    endtask

    logic [8:0] exp_x[$], exp_y[$];
    logic [8:0] bx[8], by[8];
    logic [8:0] prev_px, prev_py;
    logic [3:0] prev_size;
    logic       stall_prev, saw_block, in_fire;
    int         sent, got;

    initial begin
        // reference combinational block
        c_x = 9'd20; c_y = 9'd15; c_m = 9'd0; c_n = 9'd0; c_rate = 2'd3;
        #1;
        chk("calc_sx", 32'(c_sx), 32'd160);
        chk("calc_px", 32'(c_px), 32'd320);
        chk("calc_vis_edge", 32'(c_vis), 32'd0);
        c_x = 9'd0; c_m = 9'd200; c_rate = 2'd0;
        #1;
        chk("calc_vis_neg", 32'(c_vis), 32'd0);

        // reset state
        #20;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_px", 32'(out_px), 32'd0);
        chk("rst_out_size", 32'(out_size), 32'd1);
        chk("rst_frame_vis", 32'(frame_visible), 32'd0);
        chk("rst_frame_drop", 32'(frame_dropped), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // x1 centred, latency
        set_view(9'd100, 9'd100, 2'd0);
        send(9'd100, 9'd100);
        chk("t1_lat_s1", 32'(out_valid), 32'd0);
        tick();
        chk("t1_valid", 32'(out_valid), 32'd1);
        chk("t1_px", 32'(out_px), 32'd160);
        chk("t1_py", 32'(out_py), 32'd120);
        chk("t1_size", 32'(out_size), 32'd1);

        // x2
        set_view(9'd100, 9'd100, 2'd1);
        chk("t2_snap_vis", 32'(frame_visible), 32'd1);
        chk("t2_snap_drop", 32'(frame_dropped), 32'd0);
        send(9'd110, 9'd95);
        tick();
        chk("t2_valid", 32'(out_valid), 32'd1);
        chk("t2_px", 32'(out_px), 32'd180);
        chk("t2_py", 32'(out_py), 32'd110);
        chk("t2_size", 32'(out_size), 32'd2);

        // x8 at right/bottom edge
        set_view(9'd0, 9'd0, 2'd3);
        send(9'd19, 9'd14);
        tick();
        chk("t3_valid", 32'(out_valid), 32'd1);
        chk("t3_px", 32'(out_px), 32'd312);
        chk("t3_py", 32'(out_py), 32'd232);
        chk("t3_size", 32'(out_size), 32'd8);
        send(9'd20, 9'd15);
        tick();
        chk("t3_drop_valid", 32'(out_valid), 32'd0);
        set_view(9'd200, 9'd120, 2'd0);
        chk("t3_snap_vis", 32'(frame_visible), 32'd1);
        chk("t3_snap_drop", 32'(frame_dropped), 32'd1);

        // negative and far-positive clipping, then exact corner
        send(9'd0, 9'd0);
        tick();
        chk("t4_neg_valid", 32'(out_valid), 32'd0);
        set_view(9'd0, 9'd0, 2'd0);
        chk("t4_snap_vis", 32'(frame_visible), 32'd0);
        chk("t4_snap_drop", 32'(frame_dropped), 32'd1);
        send(9'd511, 9'd511);
        tick();
        chk("t4_far_valid", 32'(out_valid), 32'd0);
        send(9'd159, 9'd119);
        tick();
        chk("t4_corner_valid", 32'(out_valid), 32'd1);
        chk("t4_corner_px", 32'(out_px), 32'd319);
        chk("t4_corner_py", 32'(out_py), 32'd239);
        set_view(9'd160, 9'd120, 2'd0);
        chk("t4_snap2_vis", 32'(frame_visible), 32'd1);
        chk("t4_snap2_drop", 32'(frame_dropped), 32'd1);

        // burst under toggling backpressure; identity view, point 3 off-screen
        for (int i = 0; i < 8; i++) begin
            bx[i] = (i == 3) ? 9'd330 : 9'(10 + i);
            by[i] = 9'(20 + i);
            if (i != 3) begin
                exp_x.push_back(bx[i]);
                exp_y.push_back(by[i]);
            end
        end
        sent = 0; got = 0; stall_prev = 1'b0; saw_block = 1'b0;
        prev_px = '0; prev_py = '0; prev_size = '0;
        for (int cyc = 0; cyc < 200 && (got < 7 || sent < 8); cyc++) begin
            out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
            in_valid  = (sent < 8);
            if (sent < 8) begin
                in_map_x = bx[sent];
                in_map_y = by[sent];
            end
            #1;
            if (stall_prev) begin
                chk("burst_hold_valid", 32'(out_valid), 32'd1);
                chk("burst_hold_px", 32'(out_px), 32'(prev_px));
                chk("burst_hold_py", 32'(out_py), 32'(prev_py));
                chk("burst_hold_size", 32'(out_size), 32'(prev_size));
            end
            if (in_valid && !in_ready) saw_block = 1'b1;
            if (out_valid && out_ready) begin
                if (exp_x.size() == 0) begin
                    chk("burst_extra", 32'd1, 32'd0);
                end else begin
                    chk("burst_px", 32'(out_px), 32'(exp_x.pop_front()));
                    chk("burst_py", 32'(out_py), 32'(exp_y.pop_front()));
                end
                got++;
            end
            stall_prev = out_valid && !out_ready;
            prev_px = out_px; prev_py = out_py; prev_size = out_size;
            in_fire = in_valid && in_ready;
            @(posedge clk);
            #1;
            if (in_fire) sent++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        chk("burst_count", 32'(got), 32'd7);
        chk("burst_sent", 32'(sent), 32'd8);
        chk("burst_in_ready_low", 32'(saw_block), 32'd1);
        tick();

        // view change in the same cycle as an acceptance and an S2 capture
        send(9'd5, 9'd5);
        frame_start = 1'b1; m = 9'd50; n = 9'd120; rate = 2'd0;
        in_valid = 1'b1; in_map_x = 9'd100; in_map_y = 9'd100;
        tick();
        frame_start = 1'b0;
        chk("t6_p0_valid", 32'(out_valid), 32'd1);
        chk("t6_p0_px", 32'(out_px), 32'd5);
        chk("t6_snap_vis", 32'(frame_visible), 32'd8);
        chk("t6_snap_drop", 32'(frame_dropped), 32'd1);
        tick();
        in_valid = 1'b0;
        chk("t6_old_view_px", 32'(out_px), 32'd100);
        chk("t6_old_view_py", 32'(out_py), 32'd100);
        tick();
        chk("t6_new_view_valid", 32'(out_valid), 32'd1);
        chk("t6_new_view_px", 32'(out_px), 32'd210);
        tick();
        set_view(9'd160, 9'd120, 2'd0);
        chk("t6_snap2_vis", 32'(frame_visible), 32'd2);
        chk("t6_snap2_drop", 32'(frame_dropped), 32'd0);

        // reset mid-flight
        send(9'd30, 9'd40);
        in_valid = 1'b1; in_map_x = 9'd31; in_map_y = 9'd41;
        tick();
        in_valid = 1'b0;
        chk("t7_pre_valid", 32'(out_valid), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("t7_rst_valid", 32'(out_valid), 32'd0);
        chk("t7_rst_frame_vis", 32'(frame_visible), 32'd0);
        chk("t7_rst_size", 32'(out_size), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("t7_in_ready", 32'(in_ready), 32'd1);
        tick();
        chk("t7_flushed", 32'(out_valid), 32'd0);
        set_view(9'd160, 9'd120, 2'd0);
        chk("t7_snap_vis", 32'(frame_visible), 32'd0);
        chk("t7_snap_drop", 32'(frame_dropped), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
